// File: rtl/rc_pot_emulator.sv
// Emulates the pot/cap side of a single-pin RC-discharge reader:
// after the reader's charge phase, holds the pad high for target ticks.
module rc_pot_emulator #(
  parameter longint unsigned CHARGE_TICKS = 240000,
  parameter int              TW           = 24,
  parameter int              CW           = 16
) (
  input  logic          clki,
  input  logic          rst,
  input  logic          line_in,
  output logic          line_drive,
  input  logic [TW-1:0] target,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] cycle_count
);

  if (CHARGE_TICKS < 1 || CHARGE_TICKS > 64'hFFFF_FFFF) begin : g_bad_ticks
    $error("CHARGE_TICKS must be in [1, 2^32-1]");
  end

  localparam logic [31:0] CT_LAST = 32'(CHARGE_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    CHARGE,
    HOLD,
    DISCHARGED
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [31:0]   charge_cnt_q, charge_cnt_d;
  logic [TW-1:0] hold_cnt_q, hold_cnt_d;
  logic [TW-1:0] target_q, target_d;
  logic          drive_q, drive_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [CW-1:0] count_q, count_d;
  logic          line_s;
  logic          rel;

  assign line_s = sync2_q;

  always_comb begin
    state_d      = state_q;
    sync1_d      = line_in;
    sync2_d      = sync1_q;
    charge_cnt_d = charge_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    target_d     = target_q;
    drive_d      = drive_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    count_d      = count_q;
    rel          = 1'b0;
    case (state_q)
      IDLE: begin
        if (line_s) begin
          state_d      = CHARGE;
          charge_cnt_d = '0;
          target_d     = target;
          drive_d      = 1'b1;
          busy_d       = 1'b1;
        end
      end
      CHARGE: begin
        // line_s is masked by our own drive here, so it is not consulted
        charge_cnt_d = charge_cnt_q + 32'd1;
        if (charge_cnt_q == CT_LAST) begin
          if (target_q == '0) begin
            rel = 1'b1;
          end else begin
            state_d    = HOLD;
            hold_cnt_d = '0;
          end
        end
      end
      HOLD: begin
        hold_cnt_d = hold_cnt_q + TW'(1);
        if (hold_cnt_q == target_q - TW'(1)) begin
          rel = 1'b1;
        end
      end
      DISCHARGED: begin
        if (!line_s) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        drive_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
    if (rel) begin
      state_d = DISCHARGED;
      drive_d = 1'b0;
      done_d  = 1'b1;
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      charge_cnt_q <= '0;
      hold_cnt_q   <= '0;
      target_q     <= '0;
      drive_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      charge_cnt_q <= charge_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      target_q     <= target_d;
      drive_q      <= drive_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      count_q      <= count_d;
    end
  end

  assign line_drive  = drive_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cycle_count = count_q;

endmodule

// File: tb/tb_rc_pot_emulator.sv
// Scoreboard bench: stimulus pushes expected pulse length and count,
// a negedge monitor measures line_drive and checks on each done pulse.
module tb_rc_pot_emulator;
  localparam int CT = 100;
  localparam int TW = 8;
  localparam int CW = 3;

  logic          clki = 1'b0;
  logic          rst = 1'b1;
  logic          tb_drive = 1'b0;
  logic          line_in;
  logic          line_drive;
  logic [TW-1:0] target = '0;
  logic          busy;
  logic          done;
  logic [CW-1:0] cycle_count;

  // pad: wired-OR of reader drive and emulator drive, weak pull-down
  assign line_in = tb_drive | line_drive;

  typedef struct {
    int len;
    int cnt;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   exp_cnt = 0;
  int   hl = 0;
  logic prev_done = 1'b0;

  always #5 clki = ~clki;

  rc_pot_emulator #(
    .CHARGE_TICKS(CT),
    .TW(TW),
    .CW(CW)
  ) dut (
    .clki(clki),
    .rst(rst),
    .line_in(line_in),
    .line_drive(line_drive),
    .target(target),
    .busy(busy),
    .done(done),
    .cycle_count(cycle_count)
  );

  task automatic chk(input string nm, input longint act, input longint req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  always @(negedge clki) begin
    if (rst) begin
      hl = 0;
      prev_done = 1'b0;
    end else begin
      if (line_drive) hl++;
      if (done) begin
        chk("done_width", longint'(prev_done), 0);
        chk("drive_low_at_done", longint'(line_drive), 0);
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("high_len", hl, e.len);
          chk("cycle_count", longint'(cycle_count), e.cnt);
        end
        hl = 0;
      end
      prev_done = done;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clki);
    #1;
  endtask

  task automatic push_exp(input int tgt);
    exp_cnt = (exp_cnt + 1) % (1 << CW);
    sb.push_back('{CT + tgt, exp_cnt});
  endtask

  task automatic wait_fall(input int bound);
    int k;
    k = 0;
    while (line_drive && k < bound) begin
      tick(1);
      k++;
    end
    if (line_drive) chk("fall_timeout", 1, 0);
  endtask

  task automatic run_cycle(input int tgt, input int mid_tgt, input bit stuck);
    target = TW'(tgt);
    push_exp(tgt);
    tb_drive = 1'b1;
    tick(2);
    chk("rise_early", longint'(line_drive), 0);
    tick(1);
    chk("rise_at_3", longint'(line_drive), 1);
    target = TW'(mid_tgt);
    tick(CT - 3);
    tb_drive = stuck;
    wait_fall(CT + tgt + 10);
    if (stuck) begin
      repeat (4) begin
        tick(10);
        chk("stuck_busy", longint'(busy), 1);
        chk("stuck_no_drive", longint'(line_drive), 0);
      end
      tb_drive = 1'b0;
    end
    tick(3);
    chk("rearm_idle", longint'(busy), 0);
  endtask

  initial begin
    rst = 1'b1;
    tick(3);
    chk("rst_drive", longint'(line_drive), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_count", longint'(cycle_count), 0);
    rst = 1'b0;

    repeat (10) begin
      tick(10);
      chk("idle_drive", longint'(line_drive), 0);
      chk("idle_busy", longint'(busy), 0);
    end
    chk("idle_count", longint'(cycle_count), 0);

    run_cycle(50, 7, 1'b0);
    run_cycle(0, 200, 1'b0);

    run_cycle(10, 20, 1'b0);
    run_cycle(20, 30, 1'b0);
    run_cycle(30, 40, 1'b0);
    run_cycle(40, 10, 1'b0);
    chk("b2b_count", longint'(cycle_count), exp_cnt);

    run_cycle($urandom_range(0, 80), $urandom_range(0, 255), 1'b1);
    run_cycle(255, 0, 1'b0);
    repeat (3) run_cycle($urandom_range(0, 80), $urandom_range(0, 255), 1'b0);
    chk("wrap_count", longint'(cycle_count), exp_cnt);

    // abandon a cycle mid-HOLD with an asynchronous reset
    target = 8'd50;
    push_exp(50);
    tb_drive = 1'b1;
    tick(3 + CT + 10);
    tb_drive = 1'b0;
    chk("in_hold", longint'(line_drive), 1);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_drive", longint'(line_drive), 0);
    chk("async_rst_busy", longint'(busy), 0);
    chk("async_rst_done", longint'(done), 0);
    sb.delete();
    exp_cnt = 0;
    tick(2);
    rst = 1'b0;
    chk("post_rst_count", longint'(cycle_count), 0);
    tick(2);
    run_cycle(25, 99, 1'b0);
    chk("post_rst_cycle", longint'(cycle_count), 1);

    tick(5);
    chk("sb_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
